// File: rtl/sm_switch_in.sv
// Board switch conditioner: per-bit 2-flop synchroniser, debounce counter and
// stable-state register, with registered rise/fall pulses and a sticky change record.
module sm_switch_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_state,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] chg_bits,
    output logic             evt_pending,
    input  logic             rd_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] chg_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= sw_raw;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic             mismatch;

            assign mismatch = (sync2_reg[gi] != sw_state[gi]);
            // The stable bit flips only on the cycle the counter hits its last value,
            // so the counter is cleared before it could ever wrap.
            assign state_next[gi] = (mismatch && (cnt_reg == CNT_LAST)) ? sync2_reg[gi]
                                                                         : sw_state[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (!mismatch || (cnt_reg == CNT_LAST)) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    // New edges are OR-ed in after the ack clear, so an edge coinciding with an ack survives.
    assign chg_next = (rd_ack ? '0 : chg_bits) | sw_rise | sw_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_state    <= '0;
            sw_rise     <= '0;
            sw_fall     <= '0;
            chg_bits    <= '0;
            evt_pending <= 1'b0;
        end else begin
            sw_state    <= state_next;
            sw_rise     <= state_next & ~sw_state;
            sw_fall     <= ~state_next & sw_state;
            chg_bits    <= chg_next;
            evt_pending <= |chg_next;
        end
    end

endmodule
